// File: rtl/arith_pkg.sv
// Shared types and helpers for the serial arithmetic blocks.
package arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sub_state_t;

  // Bit-counter width able to hold the values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bor_in, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bor_in,
  output logic d,
  output logic bor_out
);

  assign d       = a ^ b ^ bor_in;
  assign bor_out = (~a & b) | (~(a ^ b) & bor_in);

endmodule

// File: rtl/serial_subtractor_n.sv
// Bit-serial N-bit subtractor (diff = a - b - b_in), LSB first, start/busy/done handshake.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_n
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         b_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  sub_state_t     state_r, state_nxt_s;
  logic [N-1:0]   a_sr_r, b_sr_r, diff_r, diff_shift_s;
  logic [CNT_W-1:0] cnt_r;
  logic           bor_r, b_out_r, busy_r, done_r;
  logic           load_s, last_bit_s, d_s, bor_out_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic           ovf_r;
`endif

  full_subtractor u_fs (
    .a       (a_sr_r[0]),
    .b       (b_sr_r[0]),
    .bor_in  (bor_r),
    .d       (d_s),
    .bor_out (bor_out_s)
  );

  // Next-state decode; start is accepted only in IDLE or DONE.
  always_comb begin
    state_nxt_s  = state_r;
    load_s       = 1'b0;
    last_bit_s   = (cnt_r == LAST_CNT);
    diff_shift_s = diff_r >> 1;
    diff_shift_s[N-1] = d_s;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_bit_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, operand shift registers, borrow flop and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      a_sr_r  <= {N{1'b0}};
      b_sr_r  <= {N{1'b0}};
      diff_r  <= {N{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      bor_r   <= 1'b0;
      b_out_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == S_RUN);
      done_r  <= (state_nxt_s == S_DONE);
      if (load_s) begin
        a_sr_r <= a;
        b_sr_r <= b;
        bor_r  <= b_in;
        cnt_r  <= {CNT_W{1'b0}};
      end else if (state_r == S_RUN) begin
        a_sr_r  <= a_sr_r >> 1;
        b_sr_r  <= b_sr_r >> 1;
        bor_r   <= bor_out_s;
        cnt_r   <= cnt_r + CNT_W'(1);
        diff_r  <= diff_shift_s;
        b_out_r <= bor_out_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
        // On the last bit the shift registers hold the captured operand signs.
        if (last_bit_s) begin
          ovf_r <= (a_sr_r[0] ^ b_sr_r[0]) & (d_s ^ a_sr_r[0]);
        end
`endif
      end
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign diff  = diff_r;
  assign b_out = b_out_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor_n.sv
// Scoreboard bench for serial_subtractor_n: directed cases plus random operations.
module tb_serial_subtractor_n;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic         b_in = 1'b0;
  logic         busy, done, b_out;
  logic [N-1:0] diff;
  logic         ovf_dut;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           fails = 0;
  int           last_exp = 0;
  bit           mon_en = 1'b0;
  logic [N-1:0] last_diff = '0;
  logic         last_bout = 1'b0;

  serial_subtractor_n #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow (ovf_dut)
`endif
  );

`ifndef SERIAL_SUB_OVERFLOW_EN
  assign ovf_dut = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input int av, input int bv, input int bi);
    exp_t e;
    int   r;
    r      = av - bv - bi;
    e.diff = N'(r);
    e.bout = (av < bv + bi);
    e.ovf  = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    e.ovf  = (((av >> (N - 1)) & 1) != ((bv >> (N - 1)) & 1)) &&
             (e.diff[N-1] != ((av >> (N - 1)) & 1));
`endif
    e.cyc  = 0;
    return e;
  endfunction

  // Monitor: result on done, done timing, busy window, result retention when idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() != 0) begin
        check("busy", busy, (cyc < sb[0].cyc && cyc >= sb[0].cyc - N) ? 1 : 0);
        if (done) begin
          check("done_time", cyc, sb[0].cyc);
          check("diff", diff, sb[0].diff);
          check("b_out", b_out, sb[0].bout);
`ifdef SERIAL_SUB_OVERFLOW_EN
          check("overflow", ovf_dut, sb[0].ovf);
`endif
          last_diff = sb[0].diff;
          last_bout = sb[0].bout;
          void'(sb.pop_front());
        end else if (cyc >= sb[0].cyc) begin
          check("done_missing", 0, 1);
          void'(sb.pop_front());
        end
      end else begin
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("hold_diff", diff, last_diff);
        check("hold_b_out", b_out, last_bout);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("idle_timeout", 0, 1);
      sb.delete();
    end
  endtask

  // Issue one operation; b2b drives start during the previous op's DONE cycle.
  task automatic issue(input int av, input int bv, input int bi, input bit b2b);
    exp_t e;
    if (b2b) begin
      for (int i = 0; i < 40 && cyc != last_exp; i++) @(negedge clk);
    end else begin
      wait_idle();
      @(negedge clk);
    end
    a     = N'(av);
    b     = N'(bv);
    b_in  = bi[0];
    start = 1'b1;
    e     = model(av, bv, bi);
    e.cyc = cyc + N + 1;
    last_exp = e.cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_b_out", b_out, 0);
    check("rst_ovf", ovf_dut, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    issue(9, 3, 0, 1'b0);
    issue(2, 5, 0, 1'b0);
    issue(8, 1, 0, 1'b0);
    issue(15, 15, 1, 1'b0);
    issue(7, 0, 0, 1'b1);
    issue(0, 0, 1, 1'b1);

    // start re-pulsed mid-run must be ignored
    issue(9, 3, 0, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 4'd1; b = 4'd14; b_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // asynchronous reset during the second RUN cycle
    issue(12, 5, 1, 1'b0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_diff", diff, 0);
    check("arst_b_out", b_out, 0);
    check("arst_ovf", ovf_dut, 0);
    sb.delete();
    last_diff = '0;
    last_bout = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (N + 3) @(negedge clk);
    issue(6, 10, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 2**N - 1), $urandom_range(0, 2**N - 1),
            $urandom_range(0, 1), ($urandom_range(0, 2) == 0));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_n.md
# serial_subtractor_n

Bit-serial N-bit subtractor computing diff = a − b, one bit per clock, LSB first, with a start/busy/done handshake. It is the inverse companion to the combinational `adder_n`: it trades the ripple chain for a single 1-bit borrow stage reused over N cycles. It sits in the arithmetic library beside `adder_n` for area-constrained datapaths, such as neighbour-count decrement in the cell update logic.

## Interface
- N, default 4: operand and result width in bits (N ≥ 1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active low
- start  input  1  request; sampled only in IDLE or DONE
- a  input  N  minuend, captured on accepted start
- b  input  N  subtrahend, captured on accepted start
- b_in  input  1  borrow-in, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result is valid
- diff  output  N  result a − b − b_in (mod 2^N), held until next accepted start
- b_out  output  1  final borrow-out; 1 when a < b + b_in unsigned
- overflow  output  1  signed overflow (present only with SERIAL_SUB_OVERFLOW_EN)

## Operation
- States: IDLE → RUN → DONE → IDLE. DONE lasts exactly one cycle.
- IDLE, start=1: capture a, b and b_in into shift registers and the borrow flop. Clear the bit counter. Go to RUN.
- RUN: each cycle, the full-subtractor stage takes a_sr[0], b_sr[0] and the borrow flop.
  - d = a⊕b⊕bor; bor' = (~a & b) | (~(a⊕b) & bor).
  - d shifts into the MSB of the result register. a_sr and b_sr shift right.
  - The counter increments. After the N-th bit, go to DONE.
- DONE: done=1; diff and b_out are final.
  - start=1 in DONE is accepted (back-to-back) and goes directly to RUN.
  - Otherwise go to IDLE.
- start while busy is ignored. Operands are not re-sampled.
- diff and b_out change only during RUN. In IDLE they retain the last result.
- Width rule: result is modulo 2^N. Borrow-out is the only indication of an unsigned underflow.
- Counter width: $clog2(N+1). For N=1, RUN lasts one cycle.

## Timing
- Reset values: busy=0, done=0, diff=0, b_out=0, overflow=0; state IDLE; shift registers, counter and borrow cleared.
- Reset asserted mid-RUN aborts immediately (asynchronous). No done pulse is produced.
- Latency: start sampled at edge k. busy is high for cycles k+1…k+N. done is high during cycle k+N+1.
- Throughput: one operation per N+1 cycles with back-to-back start.
- No combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined:
  - The `overflow` port exists.
  - It is registered alongside the final bit: overflow = (a[N-1] ≠ b[N-1]) & (diff[N-1] ≠ a[N-1]), using the captured operand signs.
  - Valid in DONE and held like diff.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `arith_pkg`:
  - state typedef `sub_state_t` {S_IDLE, S_RUN, S_DONE}
  - shared helper constants for counter width
- Sub-module `full_subtractor` (a, b, bor_in → d, bor_out), purely combinational. It is instantiated once, with the borrow registered in the parent.

## Test plan
- N=4, a=9, b=3, b_in=0, start pulse → busy for 4 cycles; done in cycle 5; diff=6, b_out=0.
- N=4, a=2, b=5, b_in=0 → diff=13 (4'b1101), b_out=1. With the macro: overflow=0.
- N=4, a=8 (−8), b=1, b_in=0, with the macro → diff=7, b_out=0, overflow=1.
- Back-to-back: (a=15, b=15, b_in=1), then start asserted in the DONE cycle with (a=7, b=0, b_in=0).
  - First result: diff=15, b_out=1.
  - Second done pulse exactly 5 cycles after the first, with diff=7.
- start re-pulsed mid-RUN with different operands → ignored; the original result is produced with unchanged latency.
- rst_n low during the 2nd RUN cycle → all outputs 0, state IDLE, no done pulse. A new start afterwards completes normally.
